flash_read_arbiter: RTL and testbench
=====================================

# flash_read_arbiter

Shares the single read port of the external sprite/image flash among `NREQ` requesters, such as the frame scanner, the animation sequencer and the background loader. It arbitrates round-robin and issues one read at a time on an Avalon-style port with wait-request and read-data-valid. It returns the read data to the granted requester and recovers from a flash response that never arrives, via a timeout.

## Interface
- `NREQ`, 3: number of requesters, 2..8.
- `AW`, 23: flash word-address width.
- `DW`, 16: flash data width.
- `TMO`, 255: maximum cycles in WAIT_DATA before the timeout fires, 1..65535.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NREQ: per-requester read request. The requester holds it, with its address, until it sees `req_ready`.
- `req_addr` in NREQ*AW: packed addresses; requester i uses bits [i*AW +: AW].
- `req_ready` out NREQ: one-hot accept pulse, combinational, asserted only in IDLE.
- `rsp_valid` out NREQ: one-hot, one-cycle response strobe, registered.
- `rsp_data` out DW: response data, shared by all requesters; meaningful only when `rsp_valid` is set.
- `rsp_err` out 1: qualifies `rsp_valid`; 1 means timeout, and then `rsp_data` = 0.
- `fl_read` out 1: flash read strobe.
- `fl_addr` out AW: flash address, registered.
- `fl_waitrequest` in 1: flash stall; the command is taken on the cycle with `fl_read`=1 and `fl_waitrequest`=0.
- `fl_readdata` in DW: flash read data.
- `fl_readdatavalid` in 1: flash data strobe.

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: `fl_read`=1, waiting for the command to be taken.
  - WAIT_DATA: waiting for `fl_readdatavalid`.
- Only one transaction is outstanding at a time.
- IDLE:
  - If any `req_valid` is set, grant g = the first set index searching `ptr`, `ptr`+1, … mod NREQ.
  - Drive `req_ready`[g]=1 in the same cycle.
  - Register g, `fl_addr` <= `req_addr`[g], set `ptr` <= (g+1) mod NREQ, and go to ISSUE.
  - With no request, all outputs stay idle.
- ISSUE:
  - `fl_read`=1 and `fl_addr` is held.
  - If `fl_waitrequest`=0, go to WAIT_DATA and clear the timeout counter.
  - Otherwise stay, with no limit.
- WAIT_DATA:
  - Counter increments each cycle.
  - On `fl_readdatavalid`: next cycle `rsp_valid`[g]=1, `rsp_data` = the captured `fl_readdata`, `rsp_err`=0; go to IDLE.
  - If `fl_readdatavalid` and counter==TMO occur in the same cycle, the data wins and there is no error.
  - Else, when counter reaches TMO: next cycle `rsp_valid`[g]=1, `rsp_err`=1, `rsp_data`=0; go to IDLE.
- Data handling outside WAIT_DATA:
  - `fl_readdatavalid` in IDLE or ISSUE (e.g. a late response after a timeout) is discarded.
  - Discarded data never produces `rsp_valid`.
- Other rules:
  - Requests arriving during ISSUE or WAIT_DATA wait and get no `req_ready`.
  - Dropping `req_valid` before acceptance is allowed; it simply is not granted.
  - `req_ready` and `rsp_valid` are each at most one-hot. `rsp_valid` and `req_ready` may be high in the same cycle (the response cycle is IDLE).
- Reset, at any time including mid-transaction:
  - State IDLE, `ptr`=0, g=0, counter=0.
  - `fl_read`=0, `fl_addr`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_data`=0; `req_ready`=0 while in reset.
  - Any flash data for the aborted read is discarded by the IDLE rule.

## Timing
- Accept in cycle T. The earliest sequence is:
  - `fl_read` at T+1.
  - Command taken at T+1 if `fl_waitrequest`=0.
  - WAIT_DATA from T+2.
  - `fl_readdatavalid` at T+2.
  - `rsp_valid` at T+3, together with the next possible accept.
- Minimum turnaround: 3 cycles per read. Each `fl_waitrequest` cycle adds 1; flash latency adds 1 per cycle.
- Timeout: with no data, `rsp_err` is asserted TMO+1 cycles after entering WAIT_DATA.
- Fairness: each waiting requester is granted within NREQ-1 grants to others.

## Test plan
- Single request: requester 1, addr 0x000123; flash waitrequest=0, data 0xBEEF one cycle after the command. Expected: `req_ready`=3'b010 at T, `fl_read`/`fl_addr`=0x000123 at T+1, `rsp_valid`=3'b010 and `rsp_data`=0xBEEF at T+3.
- Simultaneous requests: all three requesters request together from reset. Expected: grants in order 0, 1, 2, each returning its own address's data; no overlap of `fl_read` transactions.
- Fairness: requester 0 keeps `req_valid` high continuously while requesters 1 and 2 request once. Expected: grant sequence 0, 1, 2, 0.
- Stall: `fl_waitrequest` held high for 5 cycles. Expected: `fl_read` and `fl_addr` stable for 6 cycles; response 5 cycles later than the minimum.
- Timeout: TMO=4 with the flash never returning data. Expected: `rsp_valid`+`rsp_err`=1 and `rsp_data`=0 at the 5th cycle after entering WAIT_DATA. A later `fl_readdatavalid` pulse produces no `rsp_valid`.
- Reset mid-read: assert `rst_n` low during WAIT_DATA. Expected: all outputs 0 immediately. After release, the pending `fl_readdatavalid` is discarded and a new request to requester 2 is granted first only if 0 and 1 are idle (`ptr`=0).

Source files
------------

// File: rtl/flash_read_arbiter_if.sv
// Request/response and flash read-port bundle for flash_read_arbiter.
// master: arbiter view; slave: requesters + flash view.
interface flash_read_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 23,
  parameter int unsigned DW   = 16
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err;
  logic               fl_read;
  logic [AW-1:0]      fl_addr;
  logic               fl_waitrequest;
  logic [DW-1:0]      fl_readdata;
  logic               fl_readdatavalid;

  modport master (
    input  req_valid, req_addr, fl_waitrequest, fl_readdata, fl_readdatavalid,
    output req_ready, rsp_valid, rsp_data, rsp_err, fl_read, fl_addr
  );

  modport slave (
    output req_valid, req_addr, fl_waitrequest, fl_readdata, fl_readdatavalid,
    input  req_ready, rsp_valid, rsp_data, rsp_err, fl_read, fl_addr
  );
endinterface

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one Avalon-style flash read port among NREQ
// requesters; one read outstanding, with a response timeout.
module flash_read_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 23,
  parameter int unsigned DW   = 16,
  parameter int unsigned TMO  = 255
) (
  input  logic clk,
  input  logic rst_n,
  flash_read_arbiter_if.master bus
);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gnt_q, gnt_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;

  logic            found;
  logic [PW-1:0]   pick;
  logic [AW-1:0]   pick_addr;
  logic [NREQ-1:0] ready_raw;
  logic            fl_read_w;

  // Search starts at ptr and wraps; first requester found wins.
  always_comb begin
    int unsigned idx;
    logic [PW-1:0] idx_p;
    found     = 1'b0;
    pick      = '0;
    pick_addr = '0;
    idx       = 0;
    idx_p     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_p = PW'(idx);
      if (!found && bus.req_valid[idx_p]) begin
        found = 1'b1;
        pick  = idx_p;
      end
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (pick == PW'(j)) pick_addr = bus.req_addr[j*AW +: AW];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    ready_raw   = '0;
    fl_read_w   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          ready_raw[pick] = 1'b1;
          gnt_d   = pick;
          addr_d  = pick_addr;
          ptr_d   = (pick == PW'(NREQ - 1)) ? '0 : pick + PW'(1);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        fl_read_w = 1'b1;
        if (!bus.fl_waitrequest) begin
          cnt_d   = '0;
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        cnt_d = cnt_q + 16'd1;
        // Data arriving on the timeout cycle still counts as a good response.
        if (bus.fl_readdatavalid) begin
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_data_d         = bus.fl_readdata;
          state_d            = IDLE;
        end else if (cnt_q == 16'(TMO)) begin
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_err_d          = 1'b1;
          rsp_data_d         = '0;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.req_ready = ready_raw & {NREQ{rst_n}};
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.fl_read   = fl_read_w;
  assign bus.fl_addr   = addr_q;
endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter (NREQ=3, AW=23, DW=16, TMO=4).
module tb_flash_read_arbiter;
  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 23;
  localparam int unsigned DW   = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_asrt = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  flash_read_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  flash_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TMO(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    bus.req_addr[i*AW +: AW] = a;
  endtask

  // Full minimum-latency transaction starting in the accept cycle; ends in the
  // response cycle (which is IDLE again).
  task automatic serve(input string tag, input logic [2:0] g, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [2:0] keep);
    #1;
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'(g));
    tick();
    bus.req_valid = (bus.req_valid & ~g) | keep;
    #1;
    chk({tag, ".fl_read"}, 32'(bus.fl_read), 32'd1);
    chk({tag, ".fl_addr"}, 32'(bus.fl_addr), 32'(a));
    chk({tag, ".no_ready_issue"}, 32'(bus.req_ready), 32'd0);
    tick();
    bus.fl_readdatavalid = 1'b1;
    bus.fl_readdata      = d;
    #1;
    chk({tag, ".no_read_wait"}, 32'(bus.fl_read), 32'd0);
    chk({tag, ".no_ready_wait"}, 32'(bus.req_ready), 32'd0);
    chk({tag, ".no_rsp_early"}, 32'(bus.rsp_valid), 32'd0);
    tick();
    bus.fl_readdatavalid = 1'b0;
    #1;
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(g));
    chk({tag, ".rsp_data"}, 32'(bus.rsp_data), 32'(d));
    chk({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n                = 1'b0;
    bus.req_valid        = 3'b111;
    bus.req_addr         = '0;
    bus.fl_waitrequest   = 1'b0;
    bus.fl_readdata      = '0;
    bus.fl_readdatavalid = 1'b0;
    #1;
    chk("rst.req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.rsp_err",   32'(bus.rsp_err),   32'd0);
    chk("rst.rsp_data",  32'(bus.rsp_data),  32'd0);
    chk("rst.fl_read",   32'(bus.fl_read),   32'd0);
    chk("rst.fl_addr",   32'(bus.fl_addr),   32'd0);
    tick();
    tick();

    // Single request from requester 1
    rst_n = 1'b1;
    bus.req_valid = 3'b010;
    set_addr(1, 23'h000123);
    serve("single", 3'b010, 23'h000123, 16'hBEEF, 3'b000);
    tick();
    #1;
    chk("single.rsp_clear", 32'(bus.rsp_valid), 32'd0);

    // Simultaneous requests from reset: grants 0,1,2
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_addr(0, 23'h000010);
    set_addr(1, 23'h000020);
    set_addr(2, 23'h000030);
    bus.req_valid = 3'b111;
    serve("sim0", 3'b001, 23'h000010, 16'h1111, 3'b000);
    serve("sim1", 3'b010, 23'h000020, 16'h2222, 3'b000);
    serve("sim2", 3'b100, 23'h000030, 16'h3333, 3'b000);

    // Fairness: requester 0 held high, 1 and 2 once -> 0,1,2,0
    set_addr(0, 23'h100000);
    set_addr(1, 23'h200000);
    set_addr(2, 23'h300000);
    bus.req_valid = 3'b111;
    serve("fair0", 3'b001, 23'h100000, 16'hA000, 3'b001);
    serve("fair1", 3'b010, 23'h200000, 16'hA001, 3'b001);
    serve("fair2", 3'b100, 23'h300000, 16'hA002, 3'b001);
    serve("fair3", 3'b001, 23'h100000, 16'hA003, 3'b000);

    // Stall: waitrequest high 5 cycles (ptr=1, requester 2)
    bus.req_valid = 3'b100;
    set_addr(2, 23'h7ABCDE);
    #1;
    chk("stall.ready", 32'(bus.req_ready), 32'b100);
    tick();
    bus.req_valid = 3'b000;
    for (int i = 0; i < 6; i++) begin
      bus.fl_waitrequest = (i < 5);
      #1;
      chk("stall.fl_read", 32'(bus.fl_read), 32'd1);
      chk("stall.fl_addr", 32'(bus.fl_addr), 32'h7ABCDE);
      chk("stall.no_rsp",  32'(bus.rsp_valid), 32'd0);
      tick();
    end
    bus.fl_waitrequest   = 1'b0;
    bus.fl_readdatavalid = 1'b1;
    bus.fl_readdata      = 16'h1234;
    #1;
    chk("stall.read_low", 32'(bus.fl_read), 32'd0);
    chk("stall.no_rsp_min", 32'(bus.rsp_valid), 32'd0);
    tick();
    bus.fl_readdatavalid = 1'b0;
    #1;
    chk("stall.rsp_valid", 32'(bus.rsp_valid), 32'b100);
    chk("stall.rsp_data",  32'(bus.rsp_data),  32'h1234);

    // Timeout (TMO=4): requester 0, no data
    bus.req_valid = 3'b001;
    set_addr(0, 23'h000055);
    #1;
    chk("tmo.ready", 32'(bus.req_ready), 32'b001);
    tick();
    bus.req_valid = 3'b000;
    #1;
    chk("tmo.fl_read", 32'(bus.fl_read), 32'd1);
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("tmo.no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    tick();
    chk("tmo.rsp_valid", 32'(bus.rsp_valid), 32'b001);
    chk("tmo.rsp_err",   32'(bus.rsp_err),   32'd1);
    chk("tmo.rsp_data",  32'(bus.rsp_data),  32'd0);
    tick();
    bus.fl_readdatavalid = 1'b1;
    bus.fl_readdata      = 16'hDEAD;
    #1;
    chk("tmo.late_rsp_cycle", 32'(bus.rsp_valid), 32'd0);
    tick();
    bus.fl_readdatavalid = 1'b0;
    #1;
    chk("tmo.late_discard", 32'(bus.rsp_valid), 32'd0);
    chk("tmo.idle_read",    32'(bus.fl_read),   32'd0);

    // Data on the timeout cycle wins (requester 2, ptr=1)
    bus.req_valid = 3'b100;
    set_addr(2, 23'h3FFFFF);
    #1;
    chk("edge.ready", 32'(bus.req_ready), 32'b100);
    tick();
    bus.req_valid = 3'b000;
    tick();
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("edge.no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    tick();
    bus.fl_readdatavalid = 1'b1;
    bus.fl_readdata      = 16'h5A5A;
    #1;
    chk("edge.no_rsp_tmo", 32'(bus.rsp_valid), 32'd0);
    tick();
    bus.fl_readdatavalid = 1'b0;
    #1;
    chk("edge.rsp_valid", 32'(bus.rsp_valid), 32'b100);
    chk("edge.rsp_err",   32'(bus.rsp_err),   32'd0);
    chk("edge.rsp_data",  32'(bus.rsp_data),  32'h5A5A);

    // Reset during WAIT_DATA (requester 0 granted, ptr becomes 1)
    bus.req_valid = 3'b001;
    set_addr(0, 23'h0ABCDE);
    #1;
    chk("mid.ready", 32'(bus.req_ready), 32'b001);
    tick();
    bus.req_valid = 3'b000;
    tick();
    bus.req_valid = 3'b101;
    rst_n = 1'b0;
    #1;
    chk("mid.fl_read",   32'(bus.fl_read),   32'd0);
    chk("mid.fl_addr",   32'(bus.fl_addr),   32'd0);
    chk("mid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid.rsp_err",   32'(bus.rsp_err),   32'd0);
    chk("mid.rsp_data",  32'(bus.rsp_data),  32'd0);
    chk("mid.req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    bus.req_valid        = 3'b000;
    bus.fl_readdatavalid = 1'b1;
    bus.fl_readdata      = 16'hAAAA;
    #1;
    chk("mid.idle_ready", 32'(bus.req_ready), 32'd0);
    tick();
    bus.fl_readdatavalid = 1'b0;
    #1;
    chk("mid.discard_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid.discard_data",  32'(bus.rsp_data),  32'd0);
    set_addr(0, 23'h000777);
    set_addr(2, 23'h000999);
    bus.req_valid = 3'b101;
    serve("post0", 3'b001, 23'h000777, 16'hC0DE, 3'b000);
    serve("post2", 3'b100, 23'h000999, 16'hF00D, 3'b000);
    bus.req_valid = 3'b000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
